wb_unit: RTL and testbench

- Write-back end of the datapath: the consumer of ALU and memory results, returning them to the register file.
- Accepts one retiring instruction per handshake and selects the write-back source: load data, ALU result or PC+4.
- For loads, waits for the data-memory response and applies byte/halfword extraction with sign or zero extension.
- Produces a single-cycle registered write pulse toward Reg[].

---
 rtl/wb_unit_if.sv | 33 +++
 rtl/wb_unit.sv | 153 +++++++++++++++
 tb/tb_wb_unit.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_unit_if.sv
// Bus between the retire stage, data memory response and register-file write port of wb_unit.
// The slave modport is the write-back unit; the master modport is whoever drives it.
interface wb_unit_if;
    // Handshake: a retiring instruction transfers on a rising edge where in_valid && in_ready;
    // in_valid may be held or dropped freely, and nothing is sampled while in_ready is low.
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  wb_sel;
    logic        reg_wen;
    logic [4:0]  rd_addr;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;
    logic        state_dbg;

    modport slave (
        input  in_valid, wb_sel, reg_wen, rd_addr, funct3, alu_result, pc_plus4,
        input  mem_rvalid, mem_rdata,
        output in_ready, rf_we, rf_waddr, rf_wdata, busy, state_dbg
    );

    modport master (
        output in_valid, wb_sel, reg_wen, rd_addr, funct3, alu_result, pc_plus4,
        output mem_rvalid, mem_rdata,
        input  in_ready, rf_we, rf_waddr, rf_wdata, busy, state_dbg
    );
endinterface

// File: rtl/wb_unit.sv
// Write-back unit: selects load data, ALU result or PC+4 and issues a one-cycle register-file write.
// Optional WB_TIMEOUT_EN adds a WAIT_MEM watchdog that forces a zero write and pulses wb_timeout_err.
module wb_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    wb_unit_if.slave  bus
`ifdef WB_TIMEOUT_EN
    ,
    output logic      wb_timeout_err
`endif
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

    state_t      state, state_d;
    logic        we_q, we_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  lat_rd_q, lat_rd_d;
    logic        lat_wen_q, lat_wen_d;
    logic [2:0]  lat_f3_q, lat_f3_d;
    logic [1:0]  lat_off_q, lat_off_d;

`ifdef WB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`endif

    // Byte lanes follow the address offset; halfwords only look at off[1].
    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    extract = {{24{b[7]}}, b};
            3'd1:    extract = {{16{h[15]}}, h};
            3'd4:    extract = {24'd0, b};
            3'd5:    extract = {16'd0, h};
            default: extract = w;
        endcase
    endfunction

    always_comb begin
        state_d   = state;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        lat_rd_d  = lat_rd_q;
        lat_wen_d = lat_wen_q;
        lat_f3_d  = lat_f3_q;
        lat_off_d = lat_off_q;
`ifdef WB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.wb_sel == 2'd0) begin
                        state_d   = WAIT_MEM;
                        lat_rd_d  = bus.rd_addr;
                        lat_wen_d = bus.reg_wen;
                        lat_f3_d  = bus.funct3;
                        lat_off_d = bus.alu_result[1:0];
`ifdef WB_TIMEOUT_EN
                        cnt_d     = 8'd0;
`endif
                    end else begin
                        we_d    = bus.reg_wen && (bus.rd_addr != 5'd0);
                        waddr_d = bus.rd_addr;
                        wdata_d = (bus.wb_sel == 2'd2) ? bus.pc_plus4 : bus.alu_result;
                    end
                end
            end
            WAIT_MEM: begin
                // A response arriving in the expiry cycle still completes normally.
                if (bus.mem_rvalid) begin
                    state_d = IDLE;
                    we_d    = lat_wen_q && (lat_rd_q != 5'd0);
                    waddr_d = lat_rd_q;
                    wdata_d = extract(lat_f3_q, lat_off_q, bus.mem_rdata);
                end
`ifdef WB_TIMEOUT_EN
                else if (cnt_q == TMO_LAST) begin
                    state_d = IDLE;
                    we_d    = lat_wen_q && (lat_rd_q != 5'd0);
                    waddr_d = lat_rd_q;
                    wdata_d = 32'h0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            waddr_q   <= 5'd0;
            wdata_q   <= 32'd0;
            lat_rd_q  <= 5'd0;
            lat_wen_q <= 1'b0;
            lat_f3_q  <= 3'd0;
            lat_off_q <= 2'd0;
`ifdef WB_TIMEOUT_EN
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            lat_rd_q  <= lat_rd_d;
            lat_wen_q <= lat_wen_d;
            lat_f3_q  <= lat_f3_d;
            lat_off_q <= lat_off_d;
`ifdef WB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state == WAIT_MEM);
    assign bus.state_dbg = state;
    assign bus.rf_we     = we_q;
    assign bus.rf_waddr  = waddr_q;
    assign bus.rf_wdata  = wdata_q;
`ifdef WB_TIMEOUT_EN
    assign wb_timeout_err = err_q;
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Directed and randomized bench for wb_unit against an arithmetic load-extraction model.
// Define WB_TIMEOUT_EN on both bench and RTL to exercise the watchdog.
module tb_wb_unit;
  localparam int TMO = 4;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;

  wb_unit_if bus ();

`ifdef WB_TIMEOUT_EN
  logic err;
  wb_unit #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .wb_timeout_err(err));
`else
  wb_unit #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference load extraction written as shifts and masks.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic check_write(input string tag, input logic we, input logic [4:0] a,
                             input logic [31:0] d);
    exp_waddr = a;
    exp_wdata = d;
    chk({tag, "_we"}, 32'(bus.rf_we), 32'(we));
    chk({tag, "_waddr"}, 32'(bus.rf_waddr), 32'(exp_waddr));
    chk({tag, "_wdata"}, bus.rf_wdata, exp_wdata);
  endtask

  // driver tasks: inputs change at negedge, outputs sampled 1ns after posedge
  task automatic alu_op(input logic [1:0] sel, input logic wen, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] pc);
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.wb_sel     = sel;
    bus.reg_wen    = wen;
    bus.rd_addr    = rd;
    bus.alu_result = alu;
    bus.pc_plus4   = pc;
    bus.funct3     = 3'($urandom_range(0, 7));
    bus.mem_rvalid = 1'($urandom_range(0, 1));
    bus.mem_rdata  = $urandom;
    chk("alu_acc_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    check_write("alu", wen && (rd != 5'd0), rd, (sel == 2'd2) ? pc : alu);
    chk("alu_ready_after", 32'(bus.in_ready), 32'd1);
`ifdef WB_TIMEOUT_EN
    chk("alu_no_err", 32'(err), 32'd0);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid   = 1'b0;
      bus.mem_rvalid = 1'($urandom_range(0, 1));
      bus.mem_rdata  = $urandom;
      @(posedge clk); #1;
      chk("idle_we", 32'(bus.rf_we), 32'd0);
      chk("idle_waddr_hold", 32'(bus.rf_waddr), 32'(exp_waddr));
      chk("idle_wdata_hold", bus.rf_wdata, exp_wdata);
      chk("idle_ready", 32'(bus.in_ready), 32'd1);
    end
  endtask

  task automatic load_accept(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd,
                             input logic wen);
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.wb_sel     = 2'd0;
    bus.funct3     = f3;
    bus.rd_addr    = rd;
    bus.reg_wen    = wen;
    bus.alu_result = ($urandom & 32'hFFFF_FFFC) | {30'd0, off};
    bus.pc_plus4   = $urandom;
    bus.mem_rvalid = 1'b1;  // ignored in the accept cycle
    bus.mem_rdata  = $urandom;
    @(posedge clk); #1;
  endtask

  // Response arrives in the delay-th WAIT_MEM cycle; other inputs are scrambled meanwhile.
  task automatic load_op(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd,
                         input logic wen, input logic [31:0] data, input int delay,
                         input logic [31:0] exp);
    load_accept(f3, off, rd, wen);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      bus.in_valid   = 1'($urandom_range(0, 1));
      bus.wb_sel     = 2'd1;
      bus.rd_addr    = 5'($urandom_range(0, 31));
      bus.reg_wen    = 1'b1;
      bus.funct3     = 3'($urandom_range(0, 7));
      bus.alu_result = $urandom;
      bus.mem_rvalid = (i == delay - 1);
      bus.mem_rdata  = (i == delay - 1) ? data : $urandom;
      chk("wait_busy", 32'(bus.busy), 32'd1);
      chk("wait_ready", 32'(bus.in_ready), 32'd0);
      chk("wait_we", 32'(bus.rf_we), 32'd0);
      @(posedge clk); #1;
    end
    check_write("load", wen && (rd != 5'd0), rd, exp);
    chk("load_ready_after", 32'(bus.in_ready), 32'd1);
    chk("load_busy_after", 32'(bus.busy), 32'd0);
`ifdef WB_TIMEOUT_EN
    chk("load_no_err", 32'(err), 32'd0);
`endif
  endtask

  initial begin
    logic [1:0]  r_off;
    logic [2:0]  r_f3;
    logic [4:0]  r_rd;
    logic        r_wen;
    logic [31:0] r_data;
    int          r_kind;

    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.wb_sel     = 2'd0;
    bus.reg_wen    = 1'b0;
    bus.rd_addr    = 5'd0;
    bus.funct3     = 3'd0;
    bus.alu_result = 32'd0;
    bus.pc_plus4   = 32'd0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'd0;
    exp_waddr      = 5'd0;
    exp_wdata      = 32'd0;

    repeat (2) @(negedge clk);
    chk("rst_we", 32'(bus.rf_we), 32'd0);
    chk("rst_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("rst_wdata", bus.rf_wdata, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(bus.in_ready), 32'd1);

    // ALU write then drop
    alu_op(2'd1, 1'b1, 5'd5, 32'h1234_5678, 32'hDEAD_0000);
    idle(1);
    // JAL link, then with rd = 0
    alu_op(2'd2, 1'b1, 5'd1, 32'hAAAA_5555, 32'h0000_0104);
    alu_op(2'd2, 1'b1, 5'd0, 32'hAAAA_5555, 32'h0000_0108);
    // reserved select behaves as ALU; back-to-back pulses
    alu_op(2'd3, 1'b1, 5'd31, 32'h0BAD_CAFE, 32'h0000_0200);
    alu_op(2'd1, 1'b1, 5'd2, 32'h0000_0001, 32'h0000_0204);
    alu_op(2'd1, 1'b0, 5'd3, 32'h0000_0002, 32'h0000_0208);
    idle(2);

    // directed loads on 32'h80FF_0011
    load_op(3'd0, 2'd3, 5'd10, 1'b1, 32'h80FF_0011, 3, 32'hFFFF_FF80);
    load_op(3'd5, 2'd2, 5'd11, 1'b1, 32'h80FF_0011, 1, 32'h0000_80FF);
    load_op(3'd1, 2'd2, 5'd12, 1'b1, 32'h80FF_0011, 2, 32'hFFFF_80FF);
    load_op(3'd2, 2'd1, 5'd13, 1'b1, 32'h80FF_0011, 1, 32'h80FF_0011);
    load_op(3'd4, 2'd1, 5'd14, 1'b1, 32'h80FF_0011, 1, 32'h0000_0000);
    load_op(3'd1, 2'd1, 5'd15, 1'b1, 32'h80FF_0011, 1, 32'h0000_0011);
    load_op(3'd0, 2'd3, 5'd0, 1'b1, 32'h80FF_0011, 2, 32'hFFFF_FF80);
    alu_op(2'd1, 1'b1, 5'd7, 32'hCAFE_F00D, 32'd0);

    // reset while waiting for memory drops the load
    load_accept(3'd2, 2'd0, 5'd9, 1'b1);
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.mem_rvalid = 1'b0;
    chk("rstw_busy_before", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    exp_waddr = 5'd0;
    exp_wdata = 32'd0;
    chk("rstw_we", 32'(bus.rf_we), 32'd0);
    chk("rstw_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("rstw_wdata", bus.rf_wdata, 32'd0);
    chk("rstw_busy", 32'(bus.busy), 32'd0);
    chk("rstw_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n          = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1357_9BDF;
    @(posedge clk); #1;
    chk("rstw_after_we", 32'(bus.rf_we), 32'd0);
    chk("rstw_after_ready", 32'(bus.in_ready), 32'd1);
    chk("rstw_after_busy", 32'(bus.busy), 32'd0);
    idle(1);

`ifdef WB_TIMEOUT_EN
    // watchdog expiry with no response
    load_accept(3'd2, 2'd0, 5'd20, 1'b1);
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      bus.in_valid   = 1'b0;
      bus.mem_rvalid = 1'b0;
      chk("tmo_busy", 32'(bus.busy), 32'd1);
      chk("tmo_err_low", 32'(err), 32'd0);
      @(posedge clk); #1;
    end
    check_write("tmo", 1'b1, 5'd20, 32'h0);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_ready", 32'(bus.in_ready), 32'd1);
    idle(1);
    chk("tmo_err_clear", 32'(err), 32'd0);
    // response in the expiry cycle wins
    load_op(3'd0, 2'd3, 5'd21, 1'b1, 32'h80FF_0011, TMO, 32'hFFFF_FF80);
    idle(1);
`endif

    // randomized mix
    for (int n = 0; n < 60; n++) begin
      r_kind = $urandom_range(0, 4);
      r_rd   = 5'($urandom_range(0, 31));
      r_wen  = 1'($urandom_range(0, 1));
      r_data = $urandom;
      if (r_kind <= 1) begin
        r_f3  = 3'($urandom_range(0, 7));
        r_off = 2'($urandom_range(0, 3));
        load_op(r_f3, r_off, r_rd, r_wen, r_data, $urandom_range(1, TMO), ref_load(r_f3, r_off, r_data));
      end else if (r_kind <= 3) begin
        alu_op(2'($urandom_range(1, 3)), r_wen, r_rd, r_data, $urandom);
      end else begin
        idle(1);
      end
    end
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
